// File: rtl/first_stage_reg.sv
// First stage of a dual-rail adder/subtractor: per-bit half-sum and generate terms,
// registered as rail pairs so downstream completion logic sees only NULL or valid codes.
module first_stage_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic x3,
  input  logic x2,
  input  logic x1,
  input  logic x0,
  input  logic y3,
  input  logic y2,
  input  logic y1,
  input  logic y0,
  output logic a3_1,
  output logic a3_0,
  output logic a2_1,
  output logic a2_0,
  output logic a1_1,
  output logic a1_0,
  output logic a0_1,
  output logic a0_0,
  output logic b4_1,
  output logic b4_0,
  output logic b3_1,
  output logic b3_0,
  output logic b2_1,
  output logic b2_0,
  output logic b1_1,
  output logic b1_0
);

  logic [3:0] x;
  logic [3:0] y_eff;
  logic [3:0] a_t_d, a_t_q;
  logic [3:0] a_f_d, a_f_q;
  logic [3:0] b_t_d, b_t_q;
  logic [3:0] b_f_d, b_f_q;

  // Subtract uses the ones' complement of Y; the +1 carry-in is added downstream.
  always_comb begin
    x     = {x3, x2, x1, x0};
    y_eff = {y3, y2, y1, y0} ^ {4{s}};
    a_t_d = x ^ y_eff;
    a_f_d = ~a_t_d;
    b_t_d = x & y_eff;
    b_f_d = ~b_t_d;
  end

  // Both rails are captured on the same edge, so a pair moves NULL->valid in one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_t_q <= 4'b0000;
      a_f_q <= 4'b0000;
      b_t_q <= 4'b0000;
      b_f_q <= 4'b0000;
    end else begin
      a_t_q <= a_t_d;
      a_f_q <= a_f_d;
      b_t_q <= b_t_d;
      b_f_q <= b_f_d;
    end
  end

  assign {a3_1, a2_1, a1_1, a0_1} = a_t_q;
  assign {a3_0, a2_0, a1_0, a0_0} = a_f_q;
  assign {b4_1, b3_1, b2_1, b1_1} = b_t_q;
  assign {b4_0, b3_0, b2_0, b1_0} = b_f_q;

endmodule

// File: tb/tb_first_stage_reg.sv
// Directed bench for first_stage_reg: reset/NULL behaviour, add/sub vectors,
// extremes, exhaustive sweep, input hold between edges and mid-operation reset.
module tb_first_stage_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s = 1'b0;
  logic x3 = 1'b0, x2 = 1'b0, x1 = 1'b0, x0 = 1'b0;
  logic y3 = 1'b0, y2 = 1'b0, y1 = 1'b0, y0 = 1'b0;
  logic a3_1, a3_0, a2_1, a2_0, a1_1, a1_0, a0_1, a0_0;
  logic b4_1, b4_0, b3_1, b3_0, b2_1, b2_0, b1_1, b1_0;

  int checks = 0;
  int errors = 0;

  logic [3:0]  a_t, a_f, b_t, b_f;
  logic [15:0] outs;
  assign a_t  = {a3_1, a2_1, a1_1, a0_1};
  assign a_f  = {a3_0, a2_0, a1_0, a0_0};
  assign b_t  = {b4_1, b3_1, b2_1, b1_1};
  assign b_f  = {b4_0, b3_0, b2_0, b1_0};
  assign outs = {a_t, a_f, b_t, b_f};

  first_stage_reg dut (
    .clk (clk),  .rst_n(rst_n), .s(s),
    .x3  (x3),   .x2   (x2),    .x1(x1), .x0(x0),
    .y3  (y3),   .y2   (y2),    .y1(y1), .y0(y0),
    .a3_1(a3_1), .a3_0 (a3_0),  .a2_1(a2_1), .a2_0(a2_0),
    .a1_1(a1_1), .a1_0 (a1_0),  .a0_1(a0_1), .a0_0(a0_0),
    .b4_1(b4_1), .b4_0 (b4_0),  .b3_1(b3_1), .b3_0(b3_0),
    .b2_1(b2_1), .b2_0 (b2_0),  .b1_1(b1_1), .b1_0(b1_0)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic sv, input logic [3:0] xv, input logic [3:0] yv);
    s = sv;
    {x3, x2, x1, x0} = xv;
    {y3, y2, y1, y0} = yv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'b1010, 4'b0110);
    step();
    step();
    checks++;
    if (outs !== 16'h0000) begin
      errors++;
      $display("FAIL reset_held: got %h want 0000", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release_null: got %h want 0000", outs);
    end
    // s=1, X=1010, Y=0110 -> yE=1001, A=0011, B=1000
    step();
    checks++;
    if (outs !== {4'b0011, 4'b1100, 4'b1000, 4'b0111}) begin
      errors++;
      $display("FAIL reset_first_edge: got %h want %h", outs,
               {4'b0011, 4'b1100, 4'b1000, 4'b0111});
    end
  endtask

  task automatic test_add();
    drive(1'b0, 4'b0101, 4'b0011);
    step();
    checks++;
    if (outs !== {4'b0110, 4'b1001, 4'b0001, 4'b1110}) begin
      errors++;
      $display("FAIL add: got %h want %h", outs, {4'b0110, 4'b1001, 4'b0001, 4'b1110});
    end
  endtask

  task automatic test_sub();
    drive(1'b1, 4'b0101, 4'b0011);
    step();
    checks++;
    if (outs !== {4'b1001, 4'b0110, 4'b0100, 4'b1011}) begin
      errors++;
      $display("FAIL sub: got %h want %h", outs, {4'b1001, 4'b0110, 4'b0100, 4'b1011});
    end
  endtask

  task automatic test_extremes();
    drive(1'b0, 4'b1111, 4'b1111);
    step();
    checks++;
    if (outs !== {4'b0000, 4'b1111, 4'b1111, 4'b0000}) begin
      errors++;
      $display("FAIL ext_add_ones: got %h want %h", outs, {4'b0000, 4'b1111, 4'b1111, 4'b0000});
    end
    drive(1'b1, 4'b0000, 4'b0000);
    step();
    checks++;
    if (outs !== {4'b1111, 4'b0000, 4'b0000, 4'b1111}) begin
      errors++;
      $display("FAIL ext_sub_zero: got %h want %h", outs, {4'b1111, 4'b0000, 4'b0000, 4'b1111});
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 4'b1100, 4'b1010);
    step();
    // A=0110, B=1000; now disturb inputs between edges
    drive(1'b1, 4'b0011, 4'b0001);
    #2;
    checks++;
    if (outs !== {4'b0110, 4'b1001, 4'b1000, 4'b0111}) begin
      errors++;
      $display("FAIL hold_between_edges: got %h want %h", outs,
               {4'b0110, 4'b1001, 4'b1000, 4'b0111});
    end
    // s=1, X=0011, Y=0001 -> yE=1110, A=1101, B=0010
    step();
    checks++;
    if (outs !== {4'b1101, 4'b0010, 4'b0010, 4'b1101}) begin
      errors++;
      $display("FAIL hold_next_edge: got %h want %h", outs,
               {4'b1101, 4'b0010, 4'b0010, 4'b1101});
    end
  endtask

  task automatic test_exhaustive();
    logic       sv;
    logic [3:0] xv, yv, ye, ea, eb;
    int         bad;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      sv = i[8];
      xv = i[7:4];
      yv = i[3:0];
      drive(sv, xv, yv);
      step();
      ye = yv ^ {4{sv}};
      ea = xv ^ ye;
      eb = xv & ye;
      checks++;
      if (outs !== {ea, ~ea, eb, ~eb}) begin
        errors++;
        bad++;
        if (bad <= 8)
          $display("FAIL exhaustive s=%0b x=%b y=%b: got %h want %h", sv, xv, yv, outs,
                   {ea, ~ea, eb, ~eb});
      end
      checks++;
      if (((a_t ^ a_f) !== 4'hF) || ((b_t ^ b_f) !== 4'hF)) begin
        errors++;
        $display("FAIL exhaustive_onehot s=%0b x=%b y=%b: got %h", sv, xv, yv, outs);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 4'b1111, 4'b1111);
    step();
    checks++;
    if (outs !== {4'b0000, 4'b1111, 4'b1111, 4'b0000}) begin
      errors++;
      $display("FAIL midrst_pre: got %h want %h", outs, {4'b0000, 4'b1111, 4'b1111, 4'b0000});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_async_null: got %h want 0000", outs);
    end
    step();
    checks++;
    if (outs !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_held_over_edge: got %h want 0000", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_release_null: got %h want 0000", outs);
    end
    step();
    checks++;
    if (outs !== {4'b0000, 4'b1111, 4'b1111, 4'b0000}) begin
      errors++;
      $display("FAIL midrst_recover: got %h want %h", outs, {4'b0000, 4'b1111, 4'b1111, 4'b0000});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_extremes();
    test_hold();
    test_exhaustive();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
